// File: rtl/detector_pkg.sv
// Shared constants for the serializer feeding the 0110 sequence detector.
package detector_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with valid/ready on both sides.
// Optional gapless word streaming when BIT_SERIALIZER_BACK_TO_BACK_EN is defined.
module bit_serializer
    import detector_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             word_done
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);

    state_t             state_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [CW-1:0]      cnt_r;
    logic               out_bit_r;
    logic               out_valid_r;
    logic               word_done_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   shifted_s;
    logic               next_bit_s;
    logic               first_bit_s;

    // Acceptance window: idle, or (gapless mode) the cycle the last bit leaves.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end
`ifdef BIT_SERIALIZER_BACK_TO_BACK_EN
        else if ((state_r == ST_SHIFT) && (cnt_r == CNT_ZERO) && out_ready) begin
            in_ready_s = 1'b1;
        end
`endif
        else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Shift direction: the current bit always sits at the end that leaves first.
    always_comb begin
        shifted_s   = shreg_r;
        next_bit_s  = IDLE_BIT;
        first_bit_s = IDLE_BIT;
        if (MSB_FIRST != 0) begin
            shifted_s   = {shreg_r[WIDTH-2:0], 1'b0};
            next_bit_s  = shreg_r[WIDTH-2];
            first_bit_s = in_data[WIDTH-1];
        end else begin
            shifted_s   = {1'b0, shreg_r[WIDTH-1:1]};
            next_bit_s  = shreg_r[1];
            first_bit_s = in_data[0];
        end
    end

    // Serializer FSM with registered outputs; word_done defaults low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shreg_r     <= '0;
            cnt_r       <= CNT_ZERO;
            out_bit_r   <= IDLE_BIT;
            out_valid_r <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r     <= in_data;
                        cnt_r       <= CNT_LAST;
                        out_bit_r   <= first_bit_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end else begin
                        out_bit_r   <= IDLE_BIT;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!out_ready) begin
                        state_r <= ST_SHIFT;
                    end else if (cnt_r != CNT_ZERO) begin
                        shreg_r   <= shifted_s;
                        out_bit_r <= next_bit_s;
                        cnt_r     <= cnt_r - CNT_ONE;
                    end else begin
                        word_done_r <= 1'b1;
                        // accept_s can only be true here in gapless mode
                        if (accept_s) begin
                            shreg_r     <= in_data;
                            cnt_r       <= CNT_LAST;
                            out_bit_r   <= first_bit_s;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_bit_r   <= IDLE_BIT;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    shreg_r     <= '0;
                    cnt_r       <= CNT_ZERO;
                    out_bit_r   <= IDLE_BIT;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_bit   = out_bit_r;
    assign out_valid = out_valid_r;
    assign word_done = word_done_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, stall, reset, busy input.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_BACK_TO_BACK_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       word_done;

    logic [7:0] l_in_data;
    logic       l_in_valid;
    logic       l_in_ready;
    logic       l_out_bit;
    logic       l_out_valid;
    logic       l_out_ready;
    logic       l_word_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_ready(out_ready), .word_done(word_done)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
        .out_ready(l_out_ready), .word_done(l_word_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w36;
        logic [7:0] waa;
        logic [7:0] w7f;
        logic [7:0] w06;
        logic [3:0] hist;
        int         idx;
        int         base;
        int         run;

        w36 = 8'h36;
        waa = 8'hAA;
        w7f = 8'h7F;
        w06 = 8'h06;

        reset       = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        l_in_data   = 8'h00;
        l_in_valid  = 1'b0;
        l_out_ready = 1'b1;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_bit",   {7'd0, out_bit},   8'd0);
        chk("rst_word_done", {7'd0, word_done}, 8'd0);
        chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic MSB-first word 0x36 at full rate
        in_data  = 8'h36;
        in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) in_valid = 1'b0;
            if (c <= 8) begin
                chk($sformatf("basic_bit_c%0d", c), {7'd0, out_bit}, {7'd0, w36[8-c]});
            end
            chk($sformatf("basic_valid_c%0d", c), {7'd0, out_valid}, {7'd0, (c <= 8)});
            chk($sformatf("basic_done_c%0d", c), {7'd0, word_done}, {7'd0, (c == 9)});
            chk($sformatf("basic_ready_c%0d", c), {7'd0, in_ready},
                {7'd0, (c >= 9) || ((B2B != 0) && (c == 8))});
        end

        // Stall: bit 2 held for four cycles
        in_data  = 8'h36;
        in_valid = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 1) in_valid = 1'b0;
            idx = (c <= 2) ? c : ((c <= 5) ? 2 : c - 3);
            if (c <= 11) begin
                chk($sformatf("stall_bit_c%0d", c), {7'd0, out_bit}, {7'd0, w36[8-idx]});
            end
            chk($sformatf("stall_valid_c%0d", c), {7'd0, out_valid}, {7'd0, (c <= 11)});
            chk($sformatf("stall_done_c%0d", c), {7'd0, word_done}, {7'd0, (c == 12)});
            out_ready = !((c >= 2) && (c <= 4));
        end
        out_ready = 1'b1;

        // in_valid held high with 0xAA while 0x36 is shifting
        base = 10 - B2B;
        run  = 0;
        in_data  = 8'h36;
        in_valid = 1'b1;
        for (int c = 1; c <= base + 9; c++) begin
            step();
            if (c == 1) in_data = 8'hAA;
            chk($sformatf("busy_valid_c%0d", c), {7'd0, out_valid},
                {7'd0, (c <= 8) || ((c >= base) && (c < base + 8))});
            if (c <= 8) begin
                chk($sformatf("busy_bit_c%0d", c), {7'd0, out_bit}, {7'd0, w36[8-c]});
            end else if ((c >= base) && (c < base + 8)) begin
                chk($sformatf("busy_bit_c%0d", c), {7'd0, out_bit}, {7'd0, waa[7-(c-base)]});
            end
            chk($sformatf("busy_done_c%0d", c), {7'd0, word_done},
                {7'd0, (c == 9) || (c == base + 8)});
            if (out_valid) run++;
            if (c == base) in_valid = 1'b0;
        end
        chk("busy_valid_cycles", run[7:0], 8'd16);

        // Reset in the middle of a word
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("midrst_pre_bit", {7'd0, out_bit}, 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", {7'd0, out_valid}, 8'd0);
        chk("midrst_bit",   {7'd0, out_bit},   8'd0);
        chk("midrst_done",  {7'd0, word_done}, 8'd0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_after_done",  {7'd0, word_done}, 8'd0);
        chk("midrst_after_ready", {7'd0, in_ready},  8'd1);
        in_data  = 8'h7F;
        in_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) in_valid = 1'b0;
            if (c <= 8) begin
                chk($sformatf("fresh_bit_c%0d", c), {7'd0, out_bit}, {7'd0, w7f[8-c]});
            end
            chk($sformatf("fresh_done_c%0d", c), {7'd0, word_done}, {7'd0, (c == 9)});
        end
        step();

        // LSB-first 0x06 into a bench-side 0110 window check
        hist       = 4'b1111;
        l_in_data  = 8'h06;
        l_in_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) l_in_valid = 1'b0;
            if (c <= 8) begin
                chk($sformatf("lsb_bit_c%0d", c), {7'd0, l_out_bit}, {7'd0, w06[c-1]});
                hist = {hist[2:0], l_out_bit};
                chk($sformatf("lsb_detect_c%0d", c), {7'd0, (hist == 4'b0110)}, {7'd0, (c == 4)});
            end
            chk($sformatf("lsb_done_c%0d", c), {7'd0, l_word_done}, {7'd0, (c == 9)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the 0110 Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per accepted cycle on out_bit. out_bit connects to the detector's serial input `a`. out_ready lets the consumer stall the bit stream; word_done flags completion of each word.

Parameters:
WIDTH, 8, bits per word; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.
IDLE_BIT, 0, level driven on out_bit whenever out_valid = 0.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid; upstream holds in_data until accepted.
in_ready  output  1  serializer can accept a word this cycle (combinational).
out_bit  output  1  current serial bit (registered).
out_valid  output  1  out_bit carries a data bit (registered).
out_ready  input  1  consumer takes out_bit this cycle.
word_done  output  1  one-cycle pulse: last bit of a word consumed (registered).

Behaviour:
- Reset (async, any time) gives: state IDLE, out_valid = 0, out_bit = IDLE_BIT, word_done = 0, shift register = 0, bit count = 0. In-flight word is discarded and produces no word_done. Exit is synchronous on the first clk edge with reset low.
- States: IDLE, SHIFT. Bit counter is $clog2(WIDTH) bits and holds the number of bits remaining after the current bit.
- in_ready = (state == IDLE). The optional feature below adds one more case.
- Accept = in_valid && in_ready at a rising edge. On accept:
  - load shift register;
  - count = WIDTH-1;
  - state = SHIFT;
  - out_valid = 1;
  - out_bit = in_data[WIDTH-1] if MSB_FIRST, else in_data[0].
- Latency: first bit is visible on the cycle after accept.
- In SHIFT with out_ready = 0: hold out_bit, count and out_valid unchanged. A bit is never dropped or repeated.
- In SHIFT with out_ready = 1 and count > 0: shift toward the next bit, present it on out_bit, decrement count.
- In SHIFT with out_ready = 1 and count == 0 (last bit consumed):
  - state = IDLE;
  - out_valid = 0;
  - out_bit = IDLE_BIT;
  - word_done = 1 for exactly the next cycle.
- word_done is 0 in every other cycle.
- in_valid while busy: not accepted and does not disturb the current word. in_data may change freely while in_valid = 0.
- Minimum gap between words without the feature: 1 idle cycle (the IDLE cycle where in_ready = 1). A word of WIDTH bits takes WIDTH+1 cycles at out_ready = 1.
- No arithmetic overflow is possible. Count never wraps below 0.

Optional Feature:
BIT_SERIALIZER_BACK_TO_BACK_EN
- Defined:
  - in_ready is also 1 in SHIFT when count == 0 && out_ready == 1.
  - An accept in that cycle loads the new word directly: out_valid stays 1, count = WIDTH-1, state stays SHIFT.
  - word_done still pulses 1 on the next cycle for the completed word.
  - Result is a gapless stream: WIDTH cycles per word at out_ready = 1.
  - in_ready is combinational on out_ready in this mode.
- Undefined: behaviour exactly as above, with a mandatory IDLE cycle between words.

Decomposition:
- Shared package `detector_pkg`:
  - state encoding localparams ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - default WIDTH constant;
  - IDLE_BIT default.
- No sub-module: the counter and shift register are small enough to keep inline.
- A top-level wrapper instantiating bit_serializer feeding mealy is handled separately.

Test Plan:
- Reset mid-word: accept 8'hFF, assert reset after 3 bits -> out_valid = 0, out_bit = 0 immediately; no word_done; next accept starts fresh at bit 7.
- MSB_FIRST = 1, out_ready = 1, accept 8'h36 -> out_bit = 0,0,1,1,0,1,1,0 on cycles 1-8 after accept; word_done = 1 on cycle 9 only; in_ready = 1 on cycle 9.
- Stall: same word, out_ready = 0 for 3 cycles after bit 2 -> bit 2 held 4 cycles; sequence unchanged; word_done on cycle 12.
- in_valid held high during SHIFT with in_data = 8'hAA -> word 8'h36 output unaltered; 8'hAA accepted only on first in_ready cycle.
- MSB_FIRST = 0, accept 8'h06 -> out_bit = 0,1,1,0,0,0,0,0. Feeding the detector yields b = 1 after the 4th bit.
- BIT_SERIALIZER_BACK_TO_BACK_EN defined, in_valid always high with 8'h36 then 8'h36 -> 16 consecutive out_valid = 1 cycles; word_done pulses at cycles 9 and 17.
